// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: shared PS/2 state encodings, default timing constants and parity helper
package ps2_host_tx_pkg;

    localparam int C_DEF_INHIBIT_CYCLES = 12000;
    localparam int C_DEF_TIMEOUT_CYCLES = 1500000;

    typedef enum logic [2:0] {
        IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK, WAITIDLE
    } ps2_state_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: send handshake plus raw/open-drain PS/2 line signals
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;

    modport master (
        output tx_data, tx_valid, ps2_clk, ps2_data,
        input  tx_ready, tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe
    );

    modport slave (
        input  tx_data, tx_valid, ps2_clk, ps2_data,
        output tx_ready, tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe
    );

endinterface

// File: rtl/ps2_edge_sync.sv
// ps2_edge_sync: 2-flop synchronizers for the PS/2 lines and falling-edge detect on the clock line
module ps2_edge_sync (
    input  logic Bus2IP_Clk,
    input  logic Bus2IP_Resetn,
    input  logic i_clk,
    input  logic i_data,
    output logic o_clk_sync,
    output logic o_data_sync,
    output logic o_clk_fall
);

    logic [2:0] r_clk_sh;
    logic [1:0] r_data_sh;

    // two sync stages per line plus one history flop on clk; idle bus level is 1
    always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn) begin
            r_clk_sh  <= 3'b111;
            r_data_sh <= 2'b11;
        end else begin
            r_clk_sh  <= {r_clk_sh[1:0], i_clk};
            r_data_sh <= {r_data_sh[0], i_data};
        end
    end

    assign o_clk_sync  = r_clk_sh[1];
    assign o_data_sync = r_data_sh[1];
    assign o_clk_fall  = r_clk_sh[2] & ~r_clk_sh[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (inhibit, request-to-send, 11-bit frame, ACK)
module ps2_host_tx import ps2_host_tx_pkg::*; #(
    parameter int C_INHIBIT_CYCLES = C_DEF_INHIBIT_CYCLES,
    parameter int C_TIMEOUT_CYCLES = C_DEF_TIMEOUT_CYCLES
) (
    input logic           Bus2IP_Clk,
    input logic           Bus2IP_Resetn,
    ps2_host_tx_if.slave  bus
);

    localparam int IW = $clog2(C_INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(C_TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(C_INHIBIT_CYCLES - 1);
    localparam logic [IW-1:0] INH_PRE  = IW'(C_INHIBIT_CYCLES - 2);
    localparam logic [TW-1:0] TMO      = TW'(C_TIMEOUT_CYCLES);

    ps2_state_t    r_state;
    logic          r_clk_oe;
    logic          r_data_oe;
    logic          r_done;
    logic          r_err;
    logic [7:0]    r_sh;
    logic          r_par;
    logic [2:0]    r_bit;
    logic [IW-1:0] r_icnt;
    logic [TW-1:0] r_tcnt;
    logic          w_clk_s;
    logic          w_data_s;
    logic          w_fall;
    logic          w_active;
    logic          w_tmo;

    ps2_edge_sync u_sync (
        .Bus2IP_Clk    (Bus2IP_Clk),
        .Bus2IP_Resetn (Bus2IP_Resetn),
        .i_clk         (bus.ps2_clk),
        .i_data        (bus.ps2_data),
        .o_clk_sync    (w_clk_s),
        .o_data_sync   (w_data_s),
        .o_clk_fall    (w_fall)
    );

    assign w_active = (r_state != IDLE) && (r_state != INHIBIT);
    assign w_tmo    = w_active && (r_tcnt == TMO) && !w_fall;

    // device-clock watchdog: held at 0 until START, restarted on every falling edge
    always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn || w_fall || !w_active)
            r_tcnt <= '0;
        else if (r_tcnt != TMO)
            r_tcnt <= r_tcnt + 1'b1;
    end

    // transfer FSM with registered line enables and one-cycle done/err pulses
    always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn) begin
            r_state   <= IDLE;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_sh      <= '0;
            r_par     <= 1'b0;
            r_bit     <= '0;
            r_icnt    <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_tmo) begin
                r_clk_oe  <= 1'b0;
                r_data_oe <= 1'b0;
                r_err     <= 1'b1;
                r_state   <= IDLE;
            end else begin
                case (r_state)
                    IDLE: if (bus.tx_valid) begin
                        r_sh      <= bus.tx_data;
                        r_par     <= odd_parity(bus.tx_data);
                        r_icnt    <= '0;
                        r_clk_oe  <= 1'b1;
                        r_data_oe <= (C_INHIBIT_CYCLES == 1);
                        r_state   <= INHIBIT;
                    end
                    INHIBIT: begin
                        r_icnt <= r_icnt + 1'b1;
                        if (r_icnt == INH_PRE) r_data_oe <= 1'b1;
                        if (r_icnt == INH_LAST) begin
                            r_clk_oe  <= 1'b0;
                            r_data_oe <= 1'b1;
                            r_state   <= START;
                        end
                    end
                    START: if (w_fall) begin
                        r_data_oe <= ~r_sh[0];
                        r_sh      <= r_sh >> 1;
                        r_bit     <= '0;
                        r_state   <= DATA;
                    end
                    DATA: if (w_fall) begin
                        r_bit     <= r_bit + 1'b1;
                        r_data_oe <= (r_bit == 3'd7) ? ~r_par : ~r_sh[0];
                        r_sh      <= r_sh >> 1;
                        if (r_bit == 3'd7) r_state <= PARITY;
                    end
                    PARITY: if (w_fall) begin
                        r_data_oe <= 1'b0;
                        r_state   <= STOP;
                    end
                    STOP: if (w_fall) r_state <= ACK;
                    ACK: if (w_fall) begin
                        r_err   <= w_data_s;
                        r_state <= w_data_s ? IDLE : WAITIDLE;
                    end
                    WAITIDLE: if (w_clk_s && w_data_s) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.tx_ready    = (r_state == IDLE);
    assign bus.tx_busy     = (r_state != IDLE);
    assign bus.tx_done     = r_done;
    assign bus.tx_err      = r_err;
    assign bus.ps2_clk_oe  = r_clk_oe;
    assign bus.ps2_data_oe = r_data_oe;

endmodule
